// File: rtl/spi_ram_master.sv
// spi_ram_master: mode-0 single-lane SPI engine behind the OBI SPI-RAM shim, with its own SCK divider.
// Define SPI_RAM_MASTER_FAST_READ_EN to issue 0x0B fast reads (8 dummy cycles) instead of 0x03 reads.
module spi_ram_master #(
  parameter logic [4:0]  DefaultDivHi = 5'd1,
  parameter logic [4:0]  DefaultDivLo = 5'd1,
  parameter int unsigned MinCsHigh    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic        req_cs_i,
  input  logic [2:0]  req_md_i,
  input  logic        req_we_i,
  input  logic        req_cfg_i,
  output logic        rsp_o,
  output logic [31:0] rsp_data_o,
  input  logic        clk_cfg_i,
  input  logic [4:0]  clk_div_hi_i,
  input  logic [4:0]  clk_div_lo_i,
  output logic        spi_sck_o,
  output logic        spi_csn_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
);
`ifdef SPI_RAM_MASTER_FAST_READ_EN
  localparam int unsigned SrW  = 72;
  localparam logic [7:0]  RdOp = 8'h0B;
`else
  localparam int unsigned SrW  = 64;
  localparam logic [7:0]  RdOp = 8'h03;
`endif
  localparam logic [4:0] CsLoad = 5'(MinCsHigh - 1);

  // state  | meaning
  // IDLE   | wait for req_cs_i, apply divider updates
  // SETUP  | csn low, first bit on sdo, sck low for 1+lo cycles
  // SHIFT  | per bit: sck high for hi cycles, then low for lo cycles
  // HOLD   | csn held low for lo cycles after the last falling edge
  // CSHIGH | csn high for MinCsHigh cycles (also the abort exit)
  // DONE   | rsp_o high until req_cs_i drops
  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_CSHIGH, ST_DONE
  } state_t;

  state_t         r_state;
  logic [SrW-1:0] r_sr;
  logic [6:0]     r_bits;
  logic [4:0]     r_cnt;
  logic           r_ph;
  logic           r_rd;
  logic           r_abort;
  logic [4:0]     r_div_hi, r_div_lo;
  logic           r_pend_vld;
  logic [4:0]     r_pend_hi, r_pend_lo;

  logic [SrW-1:0] w_frame;
  logic [6:0]     w_nbits;
  logic [4:0]     w_hi_sel, w_lo_sel;
  logic           w_abort;
  logic           w_unused;

  // Counter reload for a phase length; a programmed 0 behaves as 1.
  function automatic logic [4:0] f_ld(input logic [4:0] d);
    return (d == 5'd0) ? 5'd0 : d - 5'd1;
  endfunction

  always_comb begin
    w_frame = '0;
    w_nbits = 7'd64;
    if (req_cfg_i) begin
      w_frame[SrW-1 -: 32] = {req_addr_i[7:0], req_data_i[23:0]};
      w_nbits              = 7'd32;
    end else if (req_we_i) begin
      w_frame[SrW-1 -: 64] = {8'h02, req_addr_i[23:0], req_data_i[7:0], req_data_i[15:8],
                              req_data_i[23:16], req_data_i[31:24]};
    end else begin
      w_frame[SrW-1 -: 32] = {RdOp, req_addr_i[23:0]};
      w_nbits              = 7'(SrW);
    end
  end

  assign w_hi_sel = clk_cfg_i ? clk_div_hi_i : (r_pend_vld ? r_pend_hi : r_div_hi);
  assign w_lo_sel = clk_cfg_i ? clk_div_lo_i : (r_pend_vld ? r_pend_lo : r_div_lo);
  assign w_abort  = !req_cs_i && (r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD);
  assign w_unused = ^{req_md_i, req_addr_i[31:24], r_sr[SrW-1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_sr       <= '0;
      r_bits     <= '0;
      r_cnt      <= '0;
      r_ph       <= 1'b0;
      r_rd       <= 1'b0;
      r_abort    <= 1'b0;
      r_div_hi   <= DefaultDivHi;
      r_div_lo   <= DefaultDivLo;
      r_pend_vld <= 1'b0;
      r_pend_hi  <= '0;
      r_pend_lo  <= '0;
      rsp_o      <= 1'b0;
      rsp_data_o <= '0;
      spi_sck_o  <= 1'b0;
      spi_csn_o  <= 1'b1;
      spi_sdo_o  <= 1'b0;
    end else begin
      // A frame never changes speed: updates arriving mid-frame wait for IDLE.
      if (r_state != ST_IDLE && clk_cfg_i) begin
        r_pend_vld <= 1'b1;
        r_pend_hi  <= clk_div_hi_i;
        r_pend_lo  <= clk_div_lo_i;
      end
      if (w_abort) begin
        r_state   <= ST_CSHIGH;
        r_abort   <= 1'b1;
        r_cnt     <= CsLoad;
        spi_csn_o <= 1'b1;
        spi_sck_o <= 1'b0;
        spi_sdo_o <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_div_hi   <= w_hi_sel;
            r_div_lo   <= w_lo_sel;
            r_pend_vld <= 1'b0;
            if (req_cs_i) begin
              r_sr      <= w_frame;
              r_bits    <= w_nbits;
              r_rd      <= !req_cfg_i && !req_we_i;
              r_abort   <= 1'b0;
              r_cnt     <= f_ld(w_lo_sel) + 5'd1;
              spi_csn_o <= 1'b0;
              spi_sdo_o <= w_frame[SrW-1];
              r_state   <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (r_cnt == 5'd0) begin
              r_state   <= ST_SHIFT;
              r_ph      <= 1'b1;
              spi_sck_o <= 1'b1;
              r_cnt     <= f_ld(r_div_hi);
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
          ST_SHIFT: begin
            if (r_cnt != 5'd0) begin
              r_cnt <= r_cnt - 5'd1;
            end else if (r_ph) begin
              r_sr      <= {r_sr[SrW-2:0], spi_sdi_i};
              spi_sdo_o <= (r_bits == 7'd1) ? 1'b0 : r_sr[SrW-2];
              spi_sck_o <= 1'b0;
              r_ph      <= 1'b0;
              r_bits    <= r_bits - 7'd1;
              r_cnt     <= f_ld(r_div_lo);
            end else if (r_bits == 7'd0) begin
              r_state <= ST_HOLD;
              r_cnt   <= f_ld(r_div_lo);
            end else begin
              spi_sck_o <= 1'b1;
              r_ph      <= 1'b1;
              r_cnt     <= f_ld(r_div_hi);
            end
          end
          ST_HOLD: begin
            if (r_cnt == 5'd0) begin
              r_state   <= ST_CSHIGH;
              spi_csn_o <= 1'b1;
              r_cnt     <= CsLoad;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
          ST_CSHIGH: begin
            if (r_cnt != 5'd0) begin
              r_cnt <= r_cnt - 5'd1;
            end else if (r_abort) begin
              r_state <= ST_IDLE;
            end else begin
              r_state    <= ST_DONE;
              rsp_o      <= 1'b1;
              rsp_data_o <= r_rd ? {r_sr[7:0], r_sr[15:8], r_sr[23:16], r_sr[31:24]} : 32'd0;
            end
          end
          ST_DONE: begin
            if (!req_cs_i) begin
              r_state    <= ST_IDLE;
              rsp_o      <= 1'b0;
              rsp_data_o <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
